secded_dec_pipe: RTL and testbench
==================================

SECDED_DEC_PIPE -- requirements
Module: secded_dec_pipe

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating error counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  codeword on IN is valid.
REQ-005 in_ready  output  1  block accepts IN this cycle.
REQ-006 IN  input  137  codeword: [127:0] data, [136:128] check bits, same layout as the 128-bit encoder output.
REQ-007 out_valid  output  1  OUT and flags valid.
REQ-008 out_ready  input  1  consumer accepts OUT.
REQ-009 OUT  output  128  corrected data.
REQ-010 err_corr  output  1  single error corrected (data or check bit).
REQ-011 err_uncorr  output  1  uncorrectable error detected.
REQ-012 syndrome  output  9  syndrome of the emitted word.
REQ-013 cnt_clr  input  1  synchronous clear of counters and log.
REQ-014 corr_cnt, uncorr_cnt  output  CNT_W each  saturating event counters.
REQ-015 first_uncorr_syn  output  9  syndrome of the first uncorrectable word since the last clear.

Function
REQ-016 Syndrome = check bits recomputed from IN[127:0] with the shared H matrix XOR IN[136:128]; bit k of the syndrome is check bit 128+k.
REQ-017 Syndrome 0: OUT = IN[127:0], both flags 0.
REQ-018 Syndrome equal to H column i (i in 0..127): OUT = IN[127:0] with bit i inverted, err_corr = 1.
REQ-019 Syndrome of weight 1: check-bit error, OUT = IN[127:0] unchanged, err_corr = 1.
REQ-020 Any other nonzero syndrome (even weight, or odd weight matching no column): OUT = IN[127:0] unchanged, err_uncorr = 1, err_corr = 0.
REQ-021 Two-stage pipeline: S1 registers the data and syndrome; S2 registers the corrected data, flags and syndrome.
REQ-022 Latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid when out_ready is held high.
REQ-023 Throughput is one word per cycle.
REQ-024 Each stage advances when it is empty or when its downstream stage advances; in_ready = !S1_valid || S1 advances. There is no combinational path from in_valid to out_valid.
REQ-025 While out_valid=1 and out_ready=0, OUT, flags and syndrome hold stable and no word is dropped or duplicated.
REQ-026 Counters increment once per word on the out_valid&&out_ready handshake; they saturate at 2^CNT_W-1 and do not wrap.
REQ-027 first_uncorr_syn latches on the first uncorrectable handshake after a clear; later uncorrectable words do not overwrite it.
REQ-028 cnt_clr in the same cycle as a counted handshake takes priority: the result is 0, and the log is cleared and not captured.

Reset
REQ-029 In the reset cycle: S1/S2 valid = 0, out_valid = 0, in_ready = 0.
REQ-030 After reset, all outputs other than in_ready are 0; counters and log are 0.
REQ-031 in_ready = 1 on the first cycle after rst deasserts.
REQ-032 rst asserted mid-stream discards all in-flight words; no partial output is produced.

Configuration
REQ-033 With macro SECDED_ERR_CNT_EN defined, counters and the log are implemented per REQ-026..028.
REQ-034 Without SECDED_ERR_CNT_EN, corr_cnt, uncorr_cnt and first_uncorr_syn are tied to 0, cnt_clr is ignored, and the datapath is unchanged.

Structure
REQ-035 Package secded128_pkg holds the 9x128 H-matrix column constant, DATA_W=128, CHK_W=9 and CW_W=137; the encoder is re-pointed to this package.
REQ-036 Sub-module secded_syn_calc is combinational: codeword in, 9-bit syndrome out. It is instantiated once in S1.

Verification
REQ-037 IN=137'h0 -> after 2 cycles OUT=0, flags 0, syndrome 0.
REQ-038 Valid encoding of data 128'h1 with IN[1] inverted -> OUT=128'h1, err_corr=1, syndrome=H column 1, corr_cnt=1.
REQ-039 IN=0 with IN[130] inverted -> OUT=0, err_corr=1, syndrome=9'h004.
REQ-040 IN=0 with IN[0] and IN[1] inverted -> err_uncorr=1, OUT=128'h3, first_uncorr_syn = column0 XOR column1.
REQ-041 Stream of 8 words with out_ready toggled 1,0,0,1 -> all 8 words emitted in order with none lost, and OUT is stable during stalls.
REQ-042 With CNT_W=2, 5 corrected words -> corr_cnt=3; cnt_clr then gives 0 on the next cycle.

Source files
------------

// File: rtl/secded128_pkg.sv
// Shared definitions for the 128-bit SECDED code (137-bit codeword).
// H matrix: column i is the 9-bit check pattern of data bit i. Columns are
// all weight-3 patterns in ascending order, then weight-5 patterns in
// ascending order until 128 columns exist. Every column has odd weight >= 3,
// so weight-1 syndromes always point at a check bit.
package secded128_pkg;

  localparam int DATA_W = 128;
  localparam int CHK_W  = 9;
  localparam int CW_W   = 137;

  typedef logic [DATA_W-1:0][CHK_W-1:0] h_col_t;
  typedef logic [CHK_W-1:0][DATA_W-1:0] h_row_t;

  function automatic h_col_t gen_h_cols();
    h_col_t h;
    int     n;
    logic [CHK_W-1:0] v9;
    h = '0;
    n = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 0; v < (1 << CHK_W); v++) begin
        v9 = v[CHK_W-1:0];
        if ($countones(v9) == w && n < DATA_W) begin
          h[n] = v9;
          n++;
        end
      end
    end
    return h;
  endfunction

  localparam h_col_t H_COL = gen_h_cols();

  // Row view of H: bit i of row k is set when data bit i feeds check bit k.
  function automatic h_row_t gen_h_rows();
    h_row_t r;
    r = '0;
    for (int k = 0; k < CHK_W; k++) begin
      for (int i = 0; i < DATA_W; i++) begin
        r[k][i] = H_COL[i][k];
      end
    end
    return r;
  endfunction

  localparam h_row_t H_ROW = gen_h_rows();

  // Encoder: codeword = {check bits, data}, check bit k = parity of row k.
  function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] chk;
    for (int k = 0; k < CHK_W; k++) begin
      chk[k] = ^(data & H_ROW[k]);
    end
    return {chk, data};
  endfunction

endpackage

// File: rtl/secded_syn_calc.sv
// Combinational syndrome: recomputed check bits XOR received check bits.
module secded_syn_calc
  import secded128_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [CHK_W-1:0] syn
);

  // Each syndrome bit is the parity of its H row over the data plus its check bit.
  always_comb begin
    syn = '0;
    for (int k = 0; k < CHK_W; k++) begin
      syn[k] = (^(cw[DATA_W-1:0] & H_ROW[k])) ^ cw[DATA_W+k];
    end
  end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder for 137-bit codewords.
// S1 registers data + syndrome, S2 registers corrected data, flags, syndrome.
// Optional error counters / first-uncorrectable log: macro SECDED_ERR_CNT_EN.
//
// Handshake: a word moves on a rising edge when valid && ready are both high
// on that edge. out_valid/OUT/flags hold stable while out_ready is low. A
// stage advances when it is empty or its downstream stage advances, so
// in_ready depends on out_ready but out_valid is purely registered.
module secded_dec_pipe
  import secded128_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] OUT,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [CHK_W-1:0]  syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [CHK_W-1:0]  first_uncorr_syn
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [CHK_W-1:0]  s1_syn;
  logic [CHK_W-1:0]  syn_w;
  logic              s2_valid;
  logic              s2_adv;
  logic [DATA_W-1:0] flip;
  logic              dec_corr;
  logic              dec_uncorr;
  logic              chk_err;

  secded_syn_calc u_syn (
    .cw  (IN),
    .syn (syn_w)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !rst && (!s1_valid || s2_adv);
  assign out_valid = s2_valid && !rst;

  // S1: capture data and syndrome of an accepted codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= IN[DATA_W-1:0];
        s1_syn  <= syn_w;
      end
    end
  end

  // Classify the S1 syndrome: data-column match, single check-bit, or uncorrectable.
  always_comb begin
    flip = '0;
    for (int i = 0; i < DATA_W; i++) begin
      flip[i] = (s1_syn == H_COL[i]);
    end
    chk_err    = (s1_syn != '0) && ((s1_syn & (s1_syn - 1'b1)) == '0);
    dec_corr   = (|flip) || chk_err;
    dec_uncorr = (s1_syn != '0) && !dec_corr;
  end

  // S2: register corrected word, flags and syndrome; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      OUT        <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        OUT        <= s1_data ^ flip;
        err_corr   <= dec_corr;
        err_uncorr <= dec_uncorr;
        syndrome   <= s1_syn;
      end
    end
  end

`ifdef SECDED_ERR_CNT_EN
  logic out_hs;
  logic log_vld;

  assign out_hs = out_valid && out_ready;

  // Saturating event counters and first-uncorrectable log; clear wins over capture.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt         <= '0;
      uncorr_cnt       <= '0;
      first_uncorr_syn <= '0;
      log_vld          <= 1'b0;
    end else if (out_hs) begin
      if (err_corr && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + 1'b1;
      end
      if (err_uncorr && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + 1'b1;
      end
      if (err_uncorr && !log_vld) begin
        first_uncorr_syn <= syndrome;
        log_vld          <= 1'b1;
      end
    end
  end
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr   = cnt_clr;
  assign corr_cnt         = '0;
  assign uncorr_cnt       = '0;
  assign first_uncorr_syn = '0;
`endif

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Testbench for secded_dec_pipe: directed vectors, random stream with
// backpressure, stall pattern, counter saturation/clear, mid-stream reset.
module tb_secded_dec_pipe;
  import secded128_pkg::*;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam int EW   = DATA_W + 2 + CHK_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   cw_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_corr;
  logic              err_uncorr;
  logic [CHK_W-1:0]  syndrome;
  logic              cnt_clr;
  logic [CW-1:0]     corr_cnt;
  logic [CW-1:0]     uncorr_cnt;
  logic [CHK_W-1:0]  first_uncorr_syn;

  int n_tests;
  int n_fail;

  logic [EW-1:0] exp_q[$];
  logic          prev_stall;
  logic [EW-1:0] prev_obs;
  int            n_emit;
  int            m_corr;
  int            m_uncorr;
  logic [CHK_W-1:0] m_first;
  logic          m_seen;

  secded_dec_pipe #(.CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .IN               (cw_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .OUT              (data_out),
    .err_corr         (err_corr),
    .err_uncorr       (err_uncorr),
    .syndrome         (syndrome),
    .cnt_clr          (cnt_clr),
    .corr_cnt         (corr_cnt),
    .uncorr_cnt       (uncorr_cnt),
    .first_uncorr_syn (first_uncorr_syn)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [CW_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) if (d[i]) c = c ^ H_COL[i];
    return {c, d};
  endfunction

  function automatic logic [EW-1:0] ref_decode(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    logic [CHK_W-1:0]  s;
    logic c, u;
    int hit;
    d = cw[DATA_W-1:0];
    s = cw[CW_W-1:DATA_W];
    for (int i = 0; i < DATA_W; i++) if (d[i]) s = s ^ H_COL[i];
    c = 1'b0;
    u = 1'b0;
    hit = -1;
    if (s != '0) begin
      for (int i = 0; i < DATA_W; i++) if (H_COL[i] == s) hit = i;
      if (hit >= 0) begin
        d[hit] = ~d[hit];
        c = 1'b1;
      end else if ($countones(s) == 1) c = 1'b1;
      else u = 1'b1;
    end
    return {d, c, u, s};
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef SECDED_ERR_CNT_EN
    return (n > MAXC) ? MAXC[CW-1:0] : n[CW-1:0];
`else
    return '0;
`endif
  endfunction

  function automatic logic [CHK_W-1:0] exp_log();
`ifdef SECDED_ERR_CNT_EN
    return m_first;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW_W-1:0] rand_cw();
    logic [DATA_W-1:0] d;
    logic [CW_W-1:0]   cw;
    int p1, p2;
    for (int j = 0; j < 4; j++) d[j*32 +: 32] = $urandom;
    cw = ref_encode(d);
    case ($urandom_range(0, 3))
      0: ;
      1: begin p1 = $urandom_range(0, CW_W-1); cw[p1] = ~cw[p1]; end
      2: begin
        p1 = $urandom_range(0, CW_W-1);
        p2 = (p1 + $urandom_range(1, CW_W-1)) % CW_W;
        cw[p1] = ~cw[p1];
        cw[p2] = ~cw[p2];
      end
      default: cw[CW_W-1:DATA_W] = $urandom_range(0, 511);
    endcase
    return cw;
  endfunction

  // ---------------- driver ----------------
  task automatic model_clear();
    m_corr = 0;
    m_uncorr = 0;
    m_first = '0;
    m_seen = 1'b0;
  endtask

  // One clock of streaming: drive inputs, score any output handshake,
  // check stall stability, queue accepted inputs.
  task automatic stream_cycle(input logic v, input logic [CW_W-1:0] cw,
                              input logic ordy, output logic acc);
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid  = v;
    cw_in     = cw;
    out_ready = ordy;
    #1;
    obs = {data_out, err_corr, err_uncorr, syndrome};
    if (prev_stall) begin
      n_tests++;
      if (out_valid !== 1'b1 || obs !== prev_obs) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b %h required v=1 %h", out_valid, obs, prev_obs);
      end
    end
    if (out_valid && out_ready) begin
      n_tests++;
      n_emit++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %h required no output", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL stream_word: got %h required %h", obs, e);
        end
        if (cnt_clr) model_clear();
        else begin
          if (e[CHK_W+1]) m_corr++;
          if (e[CHK_W]) begin
            m_uncorr++;
            if (!m_seen) begin m_first = e[CHK_W-1:0]; m_seen = 1'b1; end
          end
        end
      end
    end else if (cnt_clr) model_clear();
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_decode(cw));
    prev_stall = out_valid && !out_ready;
    prev_obs   = obs;
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) stream_cycle(1'b0, '0, 1'b1, acc);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    model_clear();
    prev_stall = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    #1;
    n_tests++;
    if (corr_cnt !== exp_cnt(m_corr) || uncorr_cnt !== exp_cnt(m_uncorr) ||
        first_uncorr_syn !== exp_log()) begin
      n_fail++;
      $display("FAIL %s: got corr=%0d uncorr=%0d log=%h required corr=%0d uncorr=%0d log=%h",
               tag, corr_cnt, uncorr_cnt, first_uncorr_syn,
               exp_cnt(m_corr), exp_cnt(m_uncorr), exp_log());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; cw_in = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle: got in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0 || err_corr !== 1'b0 ||
        err_uncorr !== 1'b0 || syndrome !== '0 || corr_cnt !== '0 || uncorr_cnt !== '0 ||
        first_uncorr_syn !== '0) begin
      n_fail++;
      $display("FAIL after_reset: got rdy=%b v=%b out=%h c=%b u=%b syn=%h cc=%0d uc=%0d log=%h required rdy=1 rest 0",
               in_ready, out_valid, data_out, err_corr, err_uncorr, syndrome,
               corr_cnt, uncorr_cnt, first_uncorr_syn);
    end
    model_clear();
    prev_stall = 1'b0;
  endtask

  task automatic test_directed();
    logic [CW_W-1:0] dv[4];
    logic [EW-1:0]   de[4];
    logic [CW_W-1:0] t;
    logic [EW-1:0]   obs;
    int ec[4];
    int eu[4];
    ec = '{0, 1, 2, 2};
    eu = '{0, 0, 0, 1};
    dv[0] = '0;
    de[0] = '0;
    t = {H_COL[0], 128'h1};
    t[1] = ~t[1];
    dv[1] = t;
    de[1] = {128'h1, 1'b1, 1'b0, H_COL[1]};
    t = '0;
    t[130] = 1'b1;
    dv[2] = t;
    de[2] = {128'h0, 1'b1, 1'b0, 9'h004};
    t = '0;
    t[1:0] = 2'b11;
    dv[3] = t;
    de[3] = {128'h3, 1'b0, 1'b1, H_COL[0] ^ H_COL[1]};
    pulse_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; cw_in = dv[k]; out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_in_ready: got %b required 1", k, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_early: got out_valid=%b required 0", k, out_valid);
      end
      @(negedge clk);
      #1;
      obs = {data_out, err_corr, err_uncorr, syndrome};
      n_tests++;
      if (out_valid !== 1'b1 || obs !== de[k]) begin
        n_fail++;
        $display("FAIL dir%0d_word: got v=%b %h required v=1 %h", k, out_valid, obs, de[k]);
      end
      @(negedge clk);
      m_corr = ec[k];
      m_uncorr = eu[k];
      if (k == 3) begin m_first = H_COL[0] ^ H_COL[1]; m_seen = 1'b1; end
      check_counters($sformatf("dir%0d_counters", k));
    end
    prev_stall = 1'b0;
  endtask

  task automatic test_random();
    logic acc;
    logic [CW_W-1:0] cw;
    pulse_clear();
    cw = rand_cw();
    for (int c = 0; c < 400; c++) begin
      stream_cycle($urandom_range(0, 3) != 0, cw, $urandom_range(0, 9) < 7, acc);
      if (acc) cw = rand_cw();
    end
    drain();
    @(negedge clk);
    check_counters("random_counters");
  endtask

  task automatic test_stall_pattern();
    logic acc;
    logic [CW_W-1:0] cw;
    logic ord[4];
    int sent;
    ord = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0;
    n_emit = 0;
    cw = rand_cw();
    for (int c = 0; c < 100 && sent < 8; c++) begin
      stream_cycle(1'b1, cw, ord[c % 4], acc);
      if (acc) begin sent++; cw = rand_cw(); end
    end
    drain();
    n_tests++;
    if (n_emit != 8) begin
      n_fail++;
      $display("FAIL stall_count: got %0d words required 8", n_emit);
    end
  endtask

  task automatic test_saturate_clear();
    logic acc;
    logic [CW_W-1:0] cw;
    logic [DATA_W-1:0] d;
    int p;
    pulse_clear();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) d[j*32 +: 32] = $urandom;
      cw = ref_encode(d);
      p = $urandom_range(0, DATA_W-1);
      cw[p] = ~cw[p];
      stream_cycle(1'b1, cw, 1'b1, acc);
    end
    drain();
    @(negedge clk);
    n_tests++;
    if (corr_cnt !== exp_cnt(5)) begin
      n_fail++;
      $display("FAIL saturate: got corr_cnt=%0d required %0d", corr_cnt, exp_cnt(5));
    end
    pulse_clear();
    check_counters("clear_after_sat");
  endtask

  task automatic test_clear_priority();
    logic acc;
    logic [CW_W-1:0] cw;
    pulse_clear();
    cw = '0;
    cw[5:4] = 2'b11;
    stream_cycle(1'b1, cw, 1'b1, acc);
    cnt_clr = 1'b1;
    drain();
    cnt_clr = 1'b0;
    model_clear();
    @(negedge clk);
    check_counters("clear_priority");
  endtask

  task automatic test_midstream_reset();
    logic acc;
    for (int k = 0; k < 3; k++) stream_cycle(1'b1, rand_cw(), 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_cycle: got in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    model_clear();
    prev_stall = 1'b0;
    for (int c = 0; c < 5; c++) stream_cycle(1'b0, '0, 1'b1, acc);
    check_counters("midreset_counters");
  endtask

  // Sequencer and final report
  initial begin
    n_tests = 0;
    n_fail = 0;
    n_emit = 0;
    prev_stall = 1'b0;
    prev_obs = '0;
    model_clear();
    test_reset();
    test_directed();
    test_random();
    test_stall_pattern();
    test_saturate_clear();
    test_clear_priority();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
